// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: IDLE/RUN/PAUSE FSM, four-digit BCD mm:ss counter with
// wrap pulse, and a multiplexed active-low 7-segment display driver.
module stopwatch_ctrl #(
    parameter int unsigned MAX_MIN = 59
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       scan_tick,
    input  logic       start_stop,
    input  logic       clear,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       running,
    output logic       wrap
);

    localparam logic [3:0] MAX_HI = 4'(MAX_MIN / 10);
    localparam logic [3:0] MAX_LO = 4'(MAX_MIN % 10);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t     state_r, state_s;
    logic [3:0] sec_lo_r, sec_lo_s;
    logic [3:0] sec_hi_r, sec_hi_s;
    logic [3:0] min_lo_r, min_lo_s;
    logic [3:0] min_hi_r, min_hi_s;
    logic [1:0] idx_r, idx_s;
    logic       wrap_r, wrap_s;
    logic [3:0] digit_s;

    // Segment pattern {g,f,e,d,c,b,a}, active-low; non-BCD codes blank the digit.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // State, digit, scan index and wrap registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r  <= IDLE;
            sec_lo_r <= 4'd0;
            sec_hi_r <= 4'd0;
            min_lo_r <= 4'd0;
            min_hi_r <= 4'd0;
            idx_r    <= 2'd0;
            wrap_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            sec_lo_r <= sec_lo_s;
            sec_hi_r <= sec_hi_s;
            min_lo_r <= min_lo_s;
            min_hi_r <= min_hi_s;
            idx_r    <= idx_s;
            wrap_r   <= wrap_s;
        end
    end

    // Next-state, BCD counting and scan index advance.
    always_comb begin
        state_s  = state_r;
        sec_lo_s = sec_lo_r;
        sec_hi_s = sec_hi_r;
        min_lo_s = min_lo_r;
        min_hi_s = min_hi_r;
        wrap_s   = 1'b0;
        // The scan index runs free of the FSM so the display keeps refreshing.
        if (scan_tick) begin
            idx_s = idx_r + 2'd1;
        end else begin
            idx_s = idx_r;
        end

        if (clear) begin
            state_s  = IDLE;
            sec_lo_s = 4'd0;
            sec_hi_s = 4'd0;
            min_lo_s = 4'd0;
            min_hi_s = 4'd0;
        end else begin
            // Counting keys off the current state, so a tick in the pausing cycle still counts.
            if ((state_r == RUN) && tick) begin
                if (sec_lo_r != 4'd9) begin
                    sec_lo_s = sec_lo_r + 4'd1;
                end else begin
                    sec_lo_s = 4'd0;
                    if (sec_hi_r != 4'd5) begin
                        sec_hi_s = sec_hi_r + 4'd1;
                    end else begin
                        sec_hi_s = 4'd0;
                        if ((min_hi_r == MAX_HI) && (min_lo_r == MAX_LO)) begin
                            min_lo_s = 4'd0;
                            min_hi_s = 4'd0;
                            wrap_s   = 1'b1;
                        end else if (min_lo_r != 4'd9) begin
                            min_lo_s = min_lo_r + 4'd1;
                        end else begin
                            min_lo_s = 4'd0;
                            min_hi_s = min_hi_r + 4'd1;
                        end
                    end
                end
            end else begin
                sec_lo_s = sec_lo_r;
            end

            case (state_r)
                IDLE: begin
                    if (start_stop) state_s = RUN;
                    else            state_s = IDLE;
                end
                RUN: begin
                    if (start_stop) state_s = PAUSE;
                    else            state_s = RUN;
                end
                PAUSE: begin
                    if (start_stop) state_s = RUN;
                    else            state_s = PAUSE;
                end
                default: state_s = IDLE;
            endcase
        end
    end

    // Display multiplexing straight from the registered index, digits and state.
    always_comb begin
        case (idx_r)
            2'd0:    begin an = 4'b1110; digit_s = sec_lo_r; end
            2'd1:    begin an = 4'b1101; digit_s = sec_hi_r; end
            2'd2:    begin an = 4'b1011; digit_s = min_lo_r; end
            2'd3:    begin an = 4'b0111; digit_s = min_hi_r; end
            default: begin an = 4'b1111; digit_s = 4'd0;     end
        endcase
        seg     = seg_decode(digit_s);
        dp      = ~((idx_r == 2'd2) && ((state_r == RUN) || (state_r == PAUSE)));
        running = (state_r == RUN);
        wrap    = wrap_r;
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: explicit vector tables plus a
// seconds-count reference model feeding an expected-output scoreboard.
module tb_stopwatch_ctrl;

    localparam int MAX_MIN = 59;

    logic       clk;
    logic       reset;
    logic       tick;
    logic       scan_tick;
    logic       start_stop;
    logic       clear;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       running;
    logic       wrap;

    stopwatch_ctrl #(.MAX_MIN(MAX_MIN)) dut (
        .clk        (clk),
        .reset      (reset),
        .tick       (tick),
        .scan_tick  (scan_tick),
        .start_stop (start_stop),
        .clear      (clear),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .running    (running),
        .wrap       (wrap)
    );

    typedef struct packed {
        logic       rst, tk, sc, ss, clr;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp, run, wr;
    } vec_t;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp, run, wr;
    } out_t;

    out_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: elapsed seconds as a plain integer, state 0=IDLE 1=RUN 2=PAUSE.
    int   m_secs  = 0;
    int   m_state = 0;
    int   m_idx   = 0;
    bit   m_wrap  = 1'b0;

    logic [6:0] segtab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000};

    vec_t tab_reset [2];
    vec_t tab_scan  [4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic vec_t iv(logic r, logic t, logic s, logic ss, logic c);
        vec_t v;
        v     = '0;
        v.rst = r;
        v.tk  = t;
        v.sc  = s;
        v.ss  = ss;
        v.clr = c;
        return v;
    endfunction

    task automatic model_update(input vec_t v);
        if (!v.rst) begin
            m_secs = 0; m_state = 0; m_idx = 0; m_wrap = 1'b0;
        end else begin
            m_wrap = 1'b0;
            if (v.sc) m_idx = (m_idx + 1) % 4;
            if (v.clr) begin
                m_secs = 0; m_state = 0;
            end else begin
                if (m_state == 1 && v.tk) begin
                    m_secs++;
                    if (m_secs == (MAX_MIN + 1) * 60) begin
                        m_secs = 0;
                        m_wrap = 1'b1;
                    end
                end
                if (v.ss) m_state = (m_state == 1) ? 2 : 1;
            end
        end
    endtask

    function automatic out_t model_out();
        out_t       o;
        int         d [4];
        int         s, m;
        logic [3:0] one;
        one   = 4'b0001;
        s     = m_secs % 60;
        m     = m_secs / 60;
        d[0]  = s % 10;
        d[1]  = s / 10;
        d[2]  = m % 10;
        d[3]  = m / 10;
        o.an  = ~(one << m_idx);
        o.seg = segtab[d[m_idx]];
        o.dp  = !(m_idx == 2 && m_state != 0);
        o.run = (m_state == 1);
        o.wr  = m_wrap;
        return o;
    endfunction

    task automatic cmp(input string nm, input logic [6:0] got, input logic [6:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0t got=%b exp=%b", nm, $time, got, exp);
        end
    endtask

    // Drive one cycle; expectation comes from the vector (use_tab) or the model.
    task automatic step(input vec_t v, input bit use_tab);
        out_t e, g;
        reset      = v.rst;
        tick       = v.tk;
        scan_tick  = v.sc;
        start_stop = v.ss;
        clear      = v.clr;
        model_update(v);
        if (use_tab) e = '{v.an, v.seg, v.dp, v.run, v.wr};
        else         e = model_out();
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        g = '{an, seg, dp, running, wrap};
        if (sb_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL scoreboard got=empty exp=entry");
        end else begin
            e = sb_q.pop_front();
            cmp("an",      7'(g.an), 7'(e.an));
            cmp("seg",     g.seg,    e.seg);
            cmp("dp",      7'(g.dp), 7'(e.dp));
            cmp("running", 7'(g.run), 7'(e.run));
            cmp("wrap",    7'(g.wr), 7'(e.wr));
        end
    endtask

    // Scan all four slots and check each against explicitly given digits mm:ss.
    task automatic show(input int m1, input int m0, input int s1, input int s0, input logic run);
        vec_t       v;
        int         ni, dig;
        logic [3:0] one;
        one = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            ni    = (m_idx + 1) % 4;
            dig   = (ni == 0) ? s0 : (ni == 1) ? s1 : (ni == 2) ? m0 : m1;
            v     = iv(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
            v.an  = ~(one << ni);
            v.seg = segtab[dig];
            v.dp  = !(ni == 2 && m_state != 0);
            v.run = run;
            v.wr  = 1'b0;
            step(v, 1'b1);
        end
    endtask

    task automatic do_reset();
        for (int i = 0; i < 2; i++) step(tab_reset[i], 1'b1);
    endtask

    task automatic ticks(input int n, input bit rnd_scan);
        for (int i = 0; i < n; i++)
            step(iv(1'b1, 1'b1, rnd_scan ? 1'($urandom_range(0, 1)) : 1'b0, 1'b0, 1'b0), 1'b0);
    endtask

    initial begin
        reset = 1'b0; tick = 1'b0; scan_tick = 1'b0; start_stop = 1'b0; clear = 1'b0;

        tab_reset[0] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 4'b1110, 7'b1000000, 1'b1, 1'b0, 1'b0};
        tab_reset[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1110, 7'b1000000, 1'b1, 1'b0, 1'b0};
        tab_scan[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1101, 7'b0110000, 1'b1, 1'b1, 1'b0};
        tab_scan[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1011, 7'b0100100, 1'b0, 1'b1, 1'b0};
        tab_scan[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0111, 7'b1111001, 1'b1, 1'b1, 1'b0};
        tab_scan[3]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b1110, 7'b0011001, 1'b1, 1'b1, 1'b0};

        @(posedge clk);
        #1;
        do_reset();

        // Start, 75 ticks -> 01:15 running; tick in the start cycle is ignored.
        step(iv(1'b1, 1'b1, 1'b0, 1'b1, 1'b0), 1'b0);
        ticks(75, 1'b1);
        show(0, 1, 1, 5, 1'b1);

        // start_stop+tick in RUN counts once and pauses; ticks then ignored; resume.
        step(iv(1'b1, 1'b1, 1'b0, 1'b1, 1'b0), 1'b0);
        ticks(5, 1'b1);
        show(0, 1, 1, 6, 1'b0);
        step(iv(1'b1, 1'b0, 1'b0, 1'b1, 1'b0), 1'b0);
        ticks(3, 1'b1);
        show(0, 1, 1, 9, 1'b1);

        // Clear beats start_stop and tick at 00:07 in RUN.
        do_reset();
        step(iv(1'b1, 1'b0, 1'b0, 1'b1, 1'b0), 1'b0);
        ticks(7, 1'b0);
        step(iv(1'b1, 1'b1, 1'b0, 1'b1, 1'b1), 1'b0);
        show(0, 0, 0, 0, 1'b0);

        // Display scan at 12:34 in RUN, index starting from 0.
        do_reset();
        step(iv(1'b1, 1'b0, 1'b0, 1'b1, 1'b0), 1'b0);
        ticks(754, 1'b0);
        for (int i = 0; i < 4; i++) step(tab_scan[i], 1'b1);

        // Preload to 59:59 then wrap with a one-cycle pulse, staying in RUN.
        do_reset();
        step(iv(1'b1, 1'b0, 1'b0, 1'b1, 1'b0), 1'b0);
        ticks((MAX_MIN + 1) * 60 - 1, 1'b1);
        show(5, 9, 5, 9, 1'b1);
        step(iv(1'b1, 1'b1, 1'b0, 1'b0, 1'b0), 1'b0);
        checks++;
        if (wrap !== 1'b1) begin
            errors++;
            $display("FAIL wrap_pulse got=%b exp=1", wrap);
        end
        step(iv(1'b1, 1'b0, 1'b0, 1'b0, 1'b0), 1'b0);
        show(0, 0, 0, 0, 1'b1);

        // Random mix of strobes, pauses and clears against the model.
        for (int i = 0; i < 400; i++)
            step(iv(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 31) == 0)), 1'b0);

        // Reset mid-RUN at 03:20 aborts with no wrap.
        do_reset();
        step(iv(1'b1, 1'b0, 1'b0, 1'b1, 1'b0), 1'b0);
        ticks(200, 1'b0);
        show(0, 3, 2, 0, 1'b1);
        step(tab_reset[0], 1'b1);
        show(0, 0, 0, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
